// File: rtl/ext_pkg.sv
// Shared immediate-extension encodings, used by the extension pipe and the decode stage.
package ext_pkg;

  localparam int EXT_MODE_W = 2;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_ZERO   = 2'd0,
    EXT_SIGN   = 2'd1,
    EXT_HIGH   = 2'd2,
    EXT_BRANCH = 2'd3
  } ext_mode_e;

  // Number of beats held by the two-entry pipe (output register + skid register).
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extension: zero, sign, high-half and branch-offset forms.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]       imm_i,
  input  logic [EXT_MODE_W-1:0] mode_i,
  output logic [OUT_W-1:0]      ext_o
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = {{PAD_W{1'b0}}, imm_i};
  assign sext = {{PAD_W{imm_i[IN_W-1]}}, imm_i};

  // HIGH and BRANCH shift within OUT_W, so bits above OUT_W are dropped.
  always_comb begin
    ext_o = zext;
    case (ext_mode_e'(mode_i))
      EXT_ZERO:   ext_o = zext;
      EXT_SIGN:   ext_o = sext;
      EXT_HIGH:   ext_o = zext << IN_W;
      EXT_BRANCH: ext_o = sext << 2;
      default:    ext_o = zext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// One-cycle immediate-extension stage with an output register and a skid register.
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [EXT_MODE_W-1:0] in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  input  logic                  flush,
  output occ_e                  dbg_occ
);

  if (OUT_W <= IN_W) begin : g_bad_width
    $error("imm_ext_pipe: OUT_W must be greater than IN_W");
  end

  logic [OUT_W-1:0] ext_val;

  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_vld_q, out_vld_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic             skid_vld_q, skid_vld_d;
  logic             in_rdy_q, in_rdy_d;
  logic             in_fire;
  logic             out_fire;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext_core (
    .imm_i  (in_imm),
    .mode_i (in_mode),
    .ext_o  (ext_val)
  );

  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high; valid never depends on ready, and in_ready comes straight from a flop.
  assign in_fire  = in_valid & in_rdy_q;
  assign out_fire = out_vld_q & out_ready;

  always_comb begin
    out_data_d  = out_data_q;
    out_vld_d   = out_vld_q;
    skid_data_d = skid_data_q;
    skid_vld_d  = skid_vld_q;
    if (flush) begin
      out_data_d  = '0;
      out_vld_d   = 1'b0;
      skid_data_d = '0;
      skid_vld_d  = 1'b0;
    end else if (!out_vld_q || out_fire) begin
      // Output slot frees up: the older skid beat wins over a new input beat.
      if (skid_vld_q) begin
        out_data_d = skid_data_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        out_data_d = ext_val;
        out_vld_d  = 1'b1;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (in_fire) begin
      skid_data_d = ext_val;
      skid_vld_d  = 1'b1;
    end
    in_rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      skid_data_q <= '0;
      skid_vld_q  <= 1'b0;
      in_rdy_q    <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      skid_data_q <= skid_data_d;
      skid_vld_q  <= skid_vld_d;
      in_rdy_q    <= in_rdy_d;
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;

  always_comb begin
    dbg_occ = OCC_EMPTY;
    if (skid_vld_q) begin
      dbg_occ = OCC_TWO;
    end else if (out_vld_q) begin
      dbg_occ = OCC_ONE;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: default 16->32 instance plus a 12->20 instance.
module tb_imm_ext_pipe;
  import ext_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [31:0] out_data;
  occ_e        dbg_occ;

  imm_ext_pipe u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .dbg_occ   (dbg_occ)
  );

  // ---------------- 12 -> 20 instance ----------------
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush;
  logic [11:0] s_in_imm;
  logic [1:0]  s_in_mode;
  logic [19:0] s_out_data;
  occ_e        s_dbg_occ;

  imm_ext_pipe #(
    .IN_W  (12),
    .OUT_W (20)
  ) u_dut_small (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_imm    (s_in_imm),
    .in_mode   (s_in_mode),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .flush     (s_flush),
    .dbg_occ   (s_dbg_occ)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp;
  int          n_mis;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] imm, input logic [1:0] mode);
    check_eq("send_in_ready", 32'(in_ready), 32'd1);
    in_imm   = imm;
    in_mode  = mode;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_small(input logic [11:0] imm, input logic [1:0] mode);
    s_in_imm   = imm;
    s_in_mode  = mode;
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp       = 0;
    n_mis       = 0;
    resetn      = 1'b1;
    in_valid    = 1'b0;
    in_imm      = '0;
    in_mode     = '0;
    out_ready   = 1'b1;
    flush       = 1'b0;
    s_in_valid  = 1'b0;
    s_in_imm    = '0;
    s_in_mode   = '0;
    s_out_ready = 1'b1;
    s_flush     = 1'b0;

    #3 resetn = 1'b0;
    tick();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    tick();
    resetn = 1'b1;
    #1;
    check_eq("rel_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    check_eq("rel_in_ready_high", 32'(in_ready), 32'd1);

    // Four modes on 0x8001, one cycle after acceptance each.
    send(16'h8001, EXT_ZERO);
    check_eq("zero_valid", 32'(out_valid), 32'd1);
    check_eq("zero_data", out_data, 32'h0000_8001);
    send(16'h8001, EXT_SIGN);
    check_eq("sign_data", out_data, 32'hFFFF_8001);
    send(16'h8001, EXT_HIGH);
    check_eq("high_data", out_data, 32'h8001_0000);
    send(16'h8001, EXT_BRANCH);
    check_eq("branch_valid", 32'(out_valid), 32'd1);
    check_eq("branch_data", out_data, 32'hFFFE_0004);
    tick();
    check_eq("drain_empty", 32'(out_valid), 32'd0);

    // Backpressure: A in output register, B in skid register.
    out_ready = 1'b0;
    send(16'h0001, EXT_SIGN);
    check_eq("bp_a_data", out_data, 32'h0000_0001);
    send(16'h0002, EXT_SIGN);
    check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
    check_eq("bp_occ_two", 32'(dbg_occ), 32'(OCC_TWO));
    tick();
    check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
    check_eq("bp_hold_data", out_data, 32'h0000_0001);
    out_ready = 1'b1;
    tick();
    check_eq("bp_b_valid", 32'(out_valid), 32'd1);
    check_eq("bp_b_data", out_data, 32'h0000_0002);
    check_eq("bp_in_ready_back", 32'(in_ready), 32'd1);
    tick();
    check_eq("bp_empty", 32'(out_valid), 32'd0);

    // Throughput: one beat per cycle for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      check_eq("tp_in_ready", 32'(in_ready), 32'd1);
      in_imm   = 16'(i + 16'h0100);
      in_mode  = EXT_ZERO;
      in_valid = 1'b1;
      exp_q.push_back(32'(i + 16'h0100));
      tick();
      check_eq("tp_valid", 32'(out_valid), 32'd1);
      if (exp_q.size() != 0) check_eq("tp_data", out_data, exp_q.pop_front());
    end
    in_valid = 1'b0;
    tick();
    check_eq("tp_end_empty", 32'(out_valid), 32'd0);

    // Flush with both entries full and an input beat offered.
    out_ready = 1'b0;
    send(16'h0011, EXT_ZERO);
    send(16'h0022, EXT_ZERO);
    check_eq("fl_full_in_ready", 32'(in_ready), 32'd0);
    in_imm   = 16'h0033;
    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_out_valid", 32'(out_valid), 32'd0);
    check_eq("fl_in_ready", 32'(in_ready), 32'd1);
    check_eq("fl_occ_empty", 32'(dbg_occ), 32'(OCC_EMPTY));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("fl_no_ghost", 32'(out_valid), 32'd0);
    end

    // Flush beats a simultaneous output transfer and an accepted input beat.
    out_ready = 1'b0;
    send(16'h0055, EXT_ZERO);
    out_ready = 1'b1;
    in_imm    = 16'h0066;
    in_valid  = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check_eq("fl_prio_valid", 32'(out_valid), 32'd0);
    tick();
    check_eq("fl_prio_ghost", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges while stalled.
    out_ready = 1'b0;
    send(16'h0077, EXT_ZERO);
    send(16'h0088, EXT_ZERO);
    #3 resetn = 1'b0;
    #1;
    check_eq("ar_out_valid", 32'(out_valid), 32'd0);
    check_eq("ar_in_ready", 32'(in_ready), 32'd0);
    check_eq("ar_out_data", out_data, 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    #1;
    check_eq("ar_rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("ar_first_edge_in_ready", 32'(in_ready), 32'd1);
    check_eq("ar_first_edge_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("ar_no_old_beat", 32'(out_valid), 32'd0);
    end

    // 12 -> 20 instance.
    check_eq("sm_in_ready", 32'(s_in_ready), 32'd1);
    send_small(12'h800, EXT_SIGN);
    check_eq("sm_sign_valid", 32'(s_out_valid), 32'd1);
    check_eq("sm_sign", 32'(s_out_data), 32'h000F_F800);
    send_small(12'h800, EXT_HIGH);
    check_eq("sm_high", 32'(s_out_data), 32'h0000_0000);
    send_small(12'h800, EXT_BRANCH);
    check_eq("sm_branch", 32'(s_out_data), 32'h000F_E000);
    send_small(12'h800, EXT_ZERO);
    check_eq("sm_zero", 32'(s_out_data), 32'h0000_0800);
    tick();
    check_eq("sm_empty", 32'(s_out_valid), 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
